// File: rtl/strobe_seq_gen.sv
// Multi-channel programmable strobe sequencer: per channel, after start, wait DELAY cycles,
// then emit REPEAT pulses of WIDTH cycles separated by GAP cycles. Channels are independent.
module strobe_seq_gen #(
    parameter int unsigned    NCH      = 4,
    parameter int unsigned    CNT_W    = 16,
    parameter int unsigned    REP_W    = 8,
    parameter logic [NCH-1:0] IDLE_LVL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       start,
    input  logic [NCH-1:0]       abort,
    input  logic [NCH*CNT_W-1:0] cfg_delay,
    input  logic [NCH*CNT_W-1:0] cfg_width,
    input  logic [NCH*CNT_W-1:0] cfg_gap,
    input  logic [NCH*REP_W-1:0] cfg_repeat,
    output logic [NCH-1:0]       strobe_o,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       done
);

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StActive,
        StGap
    } state_e;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [REP_W-1:0] RepOne = REP_W'(1);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] wm1_q, wm1_d;
        logic [CNT_W-1:0] gm1_q, gm1_d;
        logic [REP_W-1:0] rep_q, rep_d;
        logic             strobe_q, strobe_d;
        logic             busy_q, busy_d;
        logic             done_q, done_d;

        logic [CNT_W-1:0] cfg_d_ch, cfg_w_ch, cfg_g_ch;
        logic [REP_W-1:0] cfg_r_ch;
        logic [CNT_W-1:0] cfg_wm1, cfg_gm1;
        logic [REP_W-1:0] cfg_rm1;

        assign cfg_d_ch = cfg_delay[i*CNT_W +: CNT_W];
        assign cfg_w_ch = cfg_width[i*CNT_W +: CNT_W];
        assign cfg_g_ch = cfg_gap[i*CNT_W +: CNT_W];
        assign cfg_r_ch = cfg_repeat[i*REP_W +: REP_W];

        // Zero width/gap/repeat behave as one; counters hold N-1 so they finish at zero.
        assign cfg_wm1 = (cfg_w_ch == '0) ? '0 : cfg_w_ch - CntOne;
        assign cfg_gm1 = (cfg_g_ch == '0) ? '0 : cfg_g_ch - CntOne;
        assign cfg_rm1 = (cfg_r_ch == '0) ? '0 : cfg_r_ch - RepOne;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            wm1_d   = wm1_q;
            gm1_d   = gm1_q;
            rep_d   = rep_q;
            done_d  = 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (start[i] && !abort[i]) begin
                        wm1_d = cfg_wm1;
                        gm1_d = cfg_gm1;
                        rep_d = cfg_rm1;
                        if (cfg_d_ch != '0) begin
                            state_d = StDelay;
                            cnt_d   = cfg_d_ch - CntOne;
                        end else begin
                            state_d = StActive;
                            cnt_d   = cfg_wm1;
                        end
                    end
                end
                StDelay: begin
                    if (cnt_q == '0) begin
                        state_d = StActive;
                        cnt_d   = wm1_q;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                StActive: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CntOne;
                    end else if (rep_q == '0) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StGap;
                        cnt_d   = gm1_q;
                        rep_d   = rep_q - RepOne;
                    end
                end
                StGap: begin
                    if (cnt_q == '0) begin
                        state_d = StActive;
                        cnt_d   = wm1_q;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase

            // Abort only matters for a running sequence; in IDLE it also suppresses start above.
            if (abort[i] && (state_q != StIdle)) begin
                state_d = StIdle;
                cnt_d   = '0;
                rep_d   = '0;
                done_d  = 1'b0;
            end

            strobe_d = IDLE_LVL[i] ^ (state_d == StActive);
            busy_d   = (state_d != StIdle);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q  <= StIdle;
                cnt_q    <= '0;
                wm1_q    <= '0;
                gm1_q    <= '0;
                rep_q    <= '0;
                strobe_q <= IDLE_LVL[i];
                busy_q   <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                wm1_q    <= wm1_d;
                gm1_q    <= gm1_d;
                rep_q    <= rep_d;
                strobe_q <= strobe_d;
                busy_q   <= busy_d;
                done_q   <= done_d;
            end
        end

        assign strobe_o[i] = strobe_q;
        assign busy[i]     = busy_q;
        assign done[i]     = done_q;
    end

endmodule
